// File: rtl/adc_pulse_gen.sv
// rtl/adc_pulse_gen.sv - multi-channel baseline/rise/decay ADC stimulus pulse generator
// Define ADC_PULSE_GEN_NOISE_EN to add per-channel LFSR dither of -2..+1 LSB.
module adc_pulse_gen #(
    parameter int NCH         = 4,
    parameter int WIDTH       = 14,
    parameter int CNT_W       = 16,
    parameter int OFFSET_STEP = 10
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 STOP,
    input  logic [WIDTH-1:0]     BASELINE,
    input  logic [CNT_W-1:0]     BASE_LEN,
    input  logic [CNT_W-1:0]     RISE_LEN,
    input  logic [WIDTH-1:0]     RISE_STEP,
    input  logic [CNT_W-1:0]     FALL_LEN,
    input  logic [WIDTH-1:0]     FALL_STEP,
    input  logic [CNT_W-1:0]     REPEAT,
    output logic [NCH*WIDTH-1:0] ADC_CH,
    output logic                 TRIG,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [CNT_W-1:0]     PULSE_CNT
);

    localparam int EW = WIDTH + 2;
    localparam logic signed [EW-1:0] MAXV = EW'((1 << WIDTH) - 1);

    typedef enum logic [1:0] {IDLE, BASE, RISE, FALL} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  amp_q, amp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, pcnt_d;
    logic              trig_d, done_d, latch;
    logic              go_base, go_rise, go_fall, go_end;

    logic [WIDTH-1:0]  baseline_q, rise_step_q, fall_step_q;
    logic [CNT_W-1:0]  base_len_q, rise_len_q, fall_len_q, repeat_q;

    logic [WIDTH-1:0]  e_rise_step, e_fall_step;
    logic [CNT_W-1:0]  e_base_len, e_rise_len, e_fall_len, e_repeat;

    logic [NCH*WIDTH-1:0]   ch_d;
    logic signed [EW-1:0]   sum;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] floor_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction

    // In IDLE the start transition must see the live inputs, not the stale latch.
    always_comb begin
        if (state_q == IDLE) begin
            e_base_len  = BASE_LEN;
            e_rise_len  = RISE_LEN;
            e_rise_step = RISE_STEP;
            e_fall_len  = FALL_LEN;
            e_fall_step = FALL_STEP;
            e_repeat    = REPEAT;
        end else begin
            e_base_len  = base_len_q;
            e_rise_len  = rise_len_q;
            e_rise_step = rise_step_q;
            e_fall_len  = fall_len_q;
            e_fall_step = fall_step_q;
            e_repeat    = repeat_q;
        end
    end

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        cnt_d   = cnt_q;
        pcnt_d  = PULSE_CNT;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        latch   = 1'b0;
        go_base = 1'b0;
        go_rise = 1'b0;
        go_fall = 1'b0;
        go_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    latch   = 1'b1;
                    pcnt_d  = '0;
                    amp_d   = '0;
                    go_base = 1'b1;
                end
            end
            BASE: begin
                if (e_base_len == '0)
                    go_end = 1'b1;
                else if (cnt_q == e_base_len)
                    go_rise = 1'b1;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            RISE: begin
                if (cnt_q == e_rise_len) begin
                    go_fall = 1'b1;
                end else begin
                    amp_d = sat_add(amp_q, e_rise_step);
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FALL: begin
                if (cnt_q == e_fall_len) begin
                    go_end = 1'b1;
                end else begin
                    amp_d = floor_sub(amp_q, e_fall_step);
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Zero-length phases fall through to the next phase on the same edge.
        if (go_rise) begin
            if (e_rise_len != '0) begin
                state_d = RISE;
                cnt_d   = CNT_W'(1);
                amp_d   = sat_add(amp_q, e_rise_step);
                trig_d  = 1'b1;
            end else begin
                go_fall = 1'b1;
            end
        end
        if (go_fall) begin
            if (e_fall_len != '0) begin
                state_d = FALL;
                cnt_d   = CNT_W'(1);
                amp_d   = floor_sub(amp_q, e_fall_step);
            end else begin
                go_end = 1'b1;
            end
        end
        if (go_end) begin
            pcnt_d = PULSE_CNT + 1'b1;
            if (e_repeat == '0 || pcnt_d < e_repeat) begin
                go_base = 1'b1;
            end else begin
                state_d = IDLE;
                amp_d   = '0;
                done_d  = 1'b1;
            end
        end
        // A fresh pulse starts from amplitude 0; all-zero lengths give a 1-cycle BASE pulse.
        if (go_base) begin
            cnt_d = CNT_W'(1);
            if (e_base_len != '0) begin
                state_d = BASE;
                amp_d   = '0;
            end else if (e_rise_len != '0) begin
                state_d = RISE;
                amp_d   = e_rise_step;
                trig_d  = 1'b1;
            end else if (e_fall_len != '0) begin
                state_d = FALL;
                amp_d   = '0;
            end else begin
                state_d = BASE;
                amp_d   = '0;
                cnt_d   = '0;
            end
        end

        if (STOP) begin
            state_d = IDLE;
            amp_d   = '0;
            cnt_d   = '0;
            pcnt_d  = PULSE_CNT;
            trig_d  = 1'b0;
            done_d  = 1'b0;
            latch   = 1'b0;
        end
    end

`ifdef ADC_PULSE_GEN_NOISE_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge CLK) begin
        if (RST)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`endif

    always_comb begin
        ch_d = '0;
        sum  = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = $signed({2'b00, amp_q >> k}) + $signed({2'b00, baseline_q})
                - $signed(EW'(k * OFFSET_STEP));
`ifdef ADC_PULSE_GEN_NOISE_EN
            sum = sum + $signed({{(EW-2){1'b0}}, lfsr_q[2*k +: 2]}) - $signed(EW'(2));
`endif
            if (sum < 0)
                ch_d[k*WIDTH +: WIDTH] = '0;
            else if (sum > MAXV)
                ch_d[k*WIDTH +: WIDTH] = {WIDTH{1'b1}};
            else
                ch_d[k*WIDTH +: WIDTH] = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            amp_q       <= '0;
            cnt_q       <= '0;
            PULSE_CNT   <= '0;
            TRIG        <= 1'b0;
            DONE        <= 1'b0;
            ADC_CH      <= '0;
            baseline_q  <= '0;
            base_len_q  <= '0;
            rise_len_q  <= '0;
            rise_step_q <= '0;
            fall_len_q  <= '0;
            fall_step_q <= '0;
            repeat_q    <= '0;
        end else begin
            state_q   <= state_d;
            amp_q     <= amp_d;
            cnt_q     <= cnt_d;
            PULSE_CNT <= pcnt_d;
            TRIG      <= trig_d;
            DONE      <= done_d;
            ADC_CH    <= ch_d;
            if (latch) begin
                baseline_q  <= BASELINE;
                base_len_q  <= BASE_LEN;
                rise_len_q  <= RISE_LEN;
                rise_step_q <= RISE_STEP;
                fall_len_q  <= FALL_LEN;
                fall_step_q <= FALL_STEP;
                repeat_q    <= REPEAT;
            end
        end
    end

    assign BUSY = (state_q != IDLE);

endmodule

// File: doc/adc_pulse_gen.md
Name: adc_pulse_gen

Overview:
- Synthesizable, parametrised multi-channel ADC stimulus generator.
- Produces repeating baseline / linear-rise / linear-decay pulses on NCH parallel sample buses.
- Feeds the gpac ADC serializer model in benches, and on-board loopback tests of the ADC receiver path.
- Generalises the fixed 4-channel, fixed-shape pulse to programmable shape, repeat count, per-channel attenuation and offsets.

Parameters:
- NCH, 4: number of output channels (1..8).
- WIDTH, 14: sample width in bits.
- CNT_W, 16: width of the length and repeat counters.
- OFFSET_STEP, 10: channel k offset is BASELINE - k*OFFSET_STEP.

Ports:
- CLK  input  1  sample clock (one sample per cycle).
- RST  input  1  synchronous active-high reset.
- START  input  1  single-cycle start request.
- STOP  input  1  single-cycle abort request.
- BASELINE  input  WIDTH  baseline level of channel 0.
- BASE_LEN  input  CNT_W  cycles spent at amplitude 0.
- RISE_LEN  input  CNT_W  rise cycles.
- RISE_STEP  input  WIDTH  amplitude increment per rise cycle.
- FALL_LEN  input  CNT_W  decay cycles.
- FALL_STEP  input  WIDTH  amplitude decrement per decay cycle.
- REPEAT  input  CNT_W  pulses to generate; 0 = run until STOP.
- ADC_CH  output  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- TRIG  output  1  one-cycle pulse on the first RISE cycle.
- BUSY  output  1  high while not IDLE.
- DONE  output  1  one-cycle pulse when REPEAT pulses have completed.
- PULSE_CNT  output  CNT_W  completed pulses since last START.

Behaviour:
- States: IDLE, BASE, RISE, FALL.
- Reset (RST=1 at a CLK edge; also applies mid-operation): state IDLE, amplitude 0, ADC_CH = all zero, TRIG=0, BUSY=0, DONE=0, PULSE_CNT=0, all latched configuration = 0.
- IDLE + START:
  - Latch all configuration inputs.
  - Clear PULSE_CNT; amplitude = 0.
  - Enter BASE; BUSY=1 from the next cycle.
- Configuration changes while BUSY are ignored.
- BASE: hold amplitude 0 for BASE_LEN cycles, then RISE.
- RISE: each cycle, amplitude += RISE_STEP, saturating at 2^WIDTH-1. After RISE_LEN cycles, go to FALL.
- FALL: each cycle, amplitude -= FALL_STEP, floored at 0. After FALL_LEN cycles:
  - PULSE_CNT++.
  - If REPEAT==0 or the new PULSE_CNT<REPEAT, go to BASE.
  - Otherwise go to IDLE and pulse DONE.
- Zero-length states are skipped within the same transition; no idle cycle is inserted.
- If BASE_LEN, RISE_LEN and FALL_LEN are all 0:
  - Each pulse takes exactly 1 cycle in BASE.
  - PULSE_CNT counts once per cycle.
- TRIG: asserted in the cycle the amplitude register takes its first RISE value. Not asserted if RISE_LEN=0.
- Channel output, registered from the amplitude register (1-cycle latency):
  - ch_k = (amp >> k) + BASELINE - k*OFFSET_STEP, computed in WIDTH+2 bits.
  - Result clamped to [0, 2^WIDTH-1].
- STOP:
  - Any state goes to IDLE at the next edge; amplitude = 0.
  - No DONE; PULSE_CNT holds its value.
- START and STOP in the same cycle: STOP wins; the block stays or returns to IDLE.
- START while BUSY: ignored.
- In IDLE, ADC_CH shows baseline levels (amp = 0) using the latched BASELINE.
- PULSE_CNT wraps modulo 2^CNT_W when REPEAT=0.

Optional Feature:
- Macro ADC_PULSE_GEN_NOISE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on RST) advances every cycle.
  - Channel k adds a signed noise term equal to LFSR bits [2k+1:2k] minus 2, range -2..+1, before clamping.
- Undefined: no LFSR; output is deterministic as above.

Test Plan:
- Reset clears outputs: assert RST for 3 cycles while running → ADC_CH=0, BUSY=0, PULSE_CNT=0, TRIG=0, DONE=0 on the first cycle after release.
- Single pulse: NCH=4, BASELINE=1030, BASE_LEN=200, RISE_LEN=10, RISE_STEP=20, FALL_LEN=100, FALL_STEP=2, REPEAT=1.
  - ch0 peaks at 1230; ch1 peaks at 1120; ch3 baseline is 1000.
  - TRIG occurs 201 cycles after START.
  - DONE occurs 311 cycles after START; PULSE_CNT=1.
- Saturation and floor:
  - BASELINE=16380, RISE_STEP=100, RISE_LEN=5 → ch0 clamps at 16383.
  - FALL_STEP=1000 → amplitude floors at 0, with no wrap.
- Repeat and abort:
  - REPEAT=0, lengths 2/3/4 → PULSE_CNT increments every 9 cycles.
  - STOP mid-RISE → IDLE next cycle, no DONE, PULSE_CNT held.
- START/STOP collision and START while BUSY:
  - START and STOP asserted together → BUSY stays 0.
  - START while BUSY → latched configuration unchanged and pulse timing unchanged.
- Zero lengths: RISE_LEN=0 → no TRIG, amplitude stays 0. All lengths 0 with REPEAT=3 → DONE 3 cycles after BUSY rises.
